// File: rtl/rx_fifo_pkg.sv
// rx_fifo_pkg: shared widths so the UART receiver and its receive FIFO agree.
package rx_fifo_pkg;
    localparam int DATA_W = 8;
    localparam int RX_FIFO_ADDR_W = 3;
    localparam int RX_FIFO_THRESH = 4;
endpackage

// File: rtl/rise_edge.sv
// rise_edge: registered rising-edge detector; PREV_RST sets the history bit so a level already high at reset release is not seen as an edge.
module rise_edge #(
    parameter logic PREV_RST = 1'b1
) (
    input  logic baudClk,
    input  logic reset,
    input  logic d,
    output logic stb
);
    logic prev;
    always_ff @(posedge baudClk or posedge reset)
        prev <= reset ? PREV_RST : d;
    assign stb = d & ~prev;
endmodule

// File: rtl/rx_fifo.sv
// rx_fifo: captures one receiver byte per rxDone rising edge into a circular FIFO
// with registered read port, occupancy, threshold interrupt and sticky overflow.
import rx_fifo_pkg::*;
module rx_fifo #(
    parameter int DATA_W = rx_fifo_pkg::DATA_W,
    parameter int ADDR_W = RX_FIFO_ADDR_W,
    parameter int THRESH = RX_FIFO_THRESH
) (
    input  logic              baudClk,
    input  logic              reset,
    input  logic              rxDone,
    input  logic [DATA_W-1:0] toMem,
    input  logic              rdEn,
    input  logic              clrOvf,
    output logic [DATA_W-1:0] dataOut,
    output logic              rdValid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              thrIrq
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr, rdPtr;
    logic wrStb, rdAcc, wrAcc, drop;
    rise_edge #(.PREV_RST(1'b1)) uEdge (
        .baudClk(baudClk),
        .reset(reset),
        .d(rxDone),
        .stb(wrStb)
    );
    assign empty = count == '0;
    assign full = count == (ADDR_W+1)'(DEPTH);
    assign thrIrq = count >= (ADDR_W+1)'(THRESH);
    assign rdAcc = rdEn & ~empty;
    // a read in the same cycle frees the slot, so a write at full still lands
    assign wrAcc = wrStb & (~full | rdAcc);
    assign drop = wrStb & full & ~rdAcc;
    always_ff @(posedge baudClk)
        if (wrAcc)
            mem[wrPtr] <= toMem;
    always_ff @(posedge baudClk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            dataOut <= '0;
            rdValid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rdValid <= rdAcc;
            if (rdAcc) begin
                dataOut <= mem[rdPtr];
                rdPtr <= rdPtr + 1'b1;
            end
            if (wrAcc)
                wrPtr <= wrPtr + 1'b1;
            count <= (wrAcc & ~rdAcc) ? count + 1'b1 : (rdAcc & ~wrAcc) ? count - 1'b1 : count;
            overflow <= drop ? 1'b1 : clrOvf ? 1'b0 : overflow;
        end
    end
endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed stimulus with a queue-based reference model checked every cycle.
module tb_rx_fifo;
    logic baudClk = 0, reset = 1, rxDone = 0, rdEn = 0, clrOvf = 0;
    logic [7:0] toMem = 0;
    logic [7:0] dataOut;
    logic rdValid, empty, full, overflow, thrIrq;
    logic [3:0] count;
    int passed = 0, total = 0;

    rx_fifo dut (
        .baudClk(baudClk), .reset(reset), .rxDone(rxDone), .toMem(toMem),
        .rdEn(rdEn), .clrOvf(clrOvf), .dataOut(dataOut), .rdValid(rdValid),
        .empty(empty), .full(full), .count(count), .overflow(overflow), .thrIrq(thrIrq)
    );

    always #5 baudClk = ~baudClk;

    // reference model: a byte queue plus the few registered outputs
    logic [7:0] q[$];
    logic [7:0] mData = 0;
    logic mValid = 0, mOvf = 0, mPrev = 1;
    always @(posedge baudClk or posedge reset) begin
        if (reset) begin
            q.delete();
            mData = 0; mValid = 0; mOvf = 0; mPrev = 1;
        end else begin
            automatic logic stb = rxDone && !mPrev;
            automatic logic rd = rdEn && q.size() > 0;
            mPrev = rxDone;
            mValid = rd;
            if (rd) mData = q.pop_front();
            if (stb && q.size() < 8) q.push_back(toMem);
            else if (stb) mOvf = 1;
            else if (clrOvf) mOvf = 0;
        end
    end

    always @(negedge baudClk) begin
        automatic int n = q.size();
        automatic logic [15:0] exp = {mData, mValid, n == 0, n == 8, mOvf, n >= 4, 3'b0};
        automatic logic [15:0] act = {dataOut, rdValid, empty, full, overflow, thrIrq, 3'b0};
        total++;
        if (act === exp && count === 4'(n)) passed++;
        else $display("FAIL model t=%0t got {dout,vld,emp,full,ovf,irq}=%h cnt=%0d need %h cnt=%0d",
                      $time, act, count, exp, n);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s got %h need %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge baudClk);
        #1;
    endtask

    task automatic frame(input logic [7:0] d);
        toMem = d; rxDone = 1;
        repeat (3) tick();
        rxDone = 0;
        tick();
    endtask

    task automatic read1(input string name, input logic [7:0] exp);
        rdEn = 1;
        tick();
        rdEn = 0;
        chk(name, dataOut, exp);
        chk({name, "_vld"}, 8'(rdValid), 8'd1);
    endtask

    initial begin
        repeat (2) tick();
        reset = 0;
        tick();
        chk("rst_empty", 8'(empty), 1);
        chk("rst_count", 8'(count), 0);
        chk("rst_dout", dataOut, 0);
        chk("rst_full_irq", {6'b0, full, thrIrq}, 0);
        // single long frame -> exactly one capture
        toMem = 8'hA5; rxDone = 1;
        tick();
        chk("one_cnt_first", 8'(count), 1);
        repeat (11) tick();
        chk("one_cnt_held", 8'(count), 1);
        rxDone = 0;
        tick();
        read1("one_rd", 8'hA5);
        chk("one_empty", {3'b0, empty, count}, 8'h10);
        tick();
        chk("one_pulse", 8'(rdValid), 0);
        // fill and wrap
        for (int i = 1; i <= 8; i++) begin
            frame(8'(i));
            if (i == 3) chk("irq_below", 8'(thrIrq), 0);
            if (i == 4) chk("irq_at", 8'(thrIrq), 1);
        end
        chk("fill_full", {3'b0, full, count}, 8'h18);
        for (int i = 1; i <= 3; i++) read1("wrap_rd_a", 8'(i));
        for (int i = 9; i <= 11; i++) frame(8'(i));
        for (int i = 4; i <= 11; i++) read1("wrap_rd_b", 8'(i));
        chk("wrap_empty", 8'(empty), 1);
        // overflow
        for (int i = 1; i <= 8; i++) frame(8'h10 + 8'(i));
        frame(8'hEE);
        chk("ovf_cnt", 8'(count), 8);
        chk("ovf_set", 8'(overflow), 1);
        toMem = 8'hEF; rxDone = 1; clrOvf = 1;
        tick();
        clrOvf = 0;
        chk("ovf_set_wins", 8'(overflow), 1);
        rxDone = 0; clrOvf = 1;
        tick();
        clrOvf = 0;
        chk("ovf_clear", 8'(overflow), 0);
        // full: read and write in the same cycle
        toMem = 8'h55; rxDone = 1; rdEn = 1;
        tick();
        rdEn = 0;
        chk("sim_dout", dataOut, 8'h11);
        chk("sim_cnt", 8'(count), 8);
        chk("sim_ovf", 8'(overflow), 0);
        rxDone = 0;
        tick();
        for (int i = 2; i <= 8; i++) read1("sim_rd", 8'h10 + 8'(i));
        read1("sim_last", 8'h55);
        // empty: read with write -> no fall-through
        toMem = 8'h66; rxDone = 1; rdEn = 1;
        tick();
        rdEn = 0;
        chk("ew_vld", 8'(rdValid), 0);
        chk("ew_cnt", 8'(count), 1);
        rxDone = 0;
        tick();
        read1("ew_rd", 8'h66);
        // reset mid-operation with rxDone held high
        for (int i = 0; i < 5; i++) frame(8'h30 + 8'(i));
        read1("pre_rst", 8'h30);
        frame(8'h35);
        chk("pre_rst_cnt", 8'(count), 5);
        toMem = 8'h77; rxDone = 1; reset = 1;
        #2;
        chk("async_cnt", 8'(count), 0);
        chk("async_dout", dataOut, 0);
        tick();
        reset = 0;
        repeat (3) tick();
        chk("rst_nocap", 8'(count), 0);
        chk("rst_vld", 8'(rdValid), 0);
        rxDone = 0;
        tick();
        rxDone = 1;
        tick();
        chk("rst_recap", 8'(count), 1);
        rxDone = 0;
        tick();
        read1("rst_rd", 8'h77);
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
